// File: rtl/flit_eject.sv
// Receive-side ring endpoint: ejects flits addressed to this node into a FIFO
// and forwards everything else (plus broadcasts) with one cycle of latency.
module flit_eject #(
    parameter int FLIT_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = 8,
    parameter bit BROADCAST_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   local_id,
    input  logic [FLIT_WIDTH-1:0]   in_flit,
    input  logic                    in_enable,
    output logic [FLIT_WIDTH-1:0]   pass_flit,
    output logic                    pass_enable,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [FLIT_WIDTH-1:0] r_pass_flit;
    logic                  r_pass_enable;
    logic [CNT_WIDTH-1:0]  r_drop_count;
    logic                  r_overflow;

    logic [ADDR_WIDTH-1:0] w_dest;
    logic                  w_match;
    logic                  w_bcast;
    logic                  w_eject_req;
    logic                  w_fwd;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  w_push;
    logic                  w_drop;

    // A local-address match takes priority: it is ejected only, never forwarded.
    always_comb begin
        w_dest      = in_flit[FLIT_WIDTH-1 -: ADDR_WIDTH];
        w_match     = (w_dest == local_id);
        w_bcast     = BROADCAST_EN && (&w_dest);
        w_eject_req = in_enable && (w_match || w_bcast);
        w_fwd       = in_enable && !w_match;
        w_pop       = (r_level != '0) && out_ready;
        w_push_ok   = (r_level != FULL_LVL) || w_pop;
        w_push      = w_eject_req && w_push_ok;
        w_drop      = w_eject_req && !w_push_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_pass_flit   <= '0;
            r_pass_enable <= 1'b0;
            r_drop_count  <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_pass_enable <= w_fwd;
            if (w_fwd) begin
                r_pass_flit <= in_flit;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (!(&r_drop_count)) begin
                    r_drop_count <= r_drop_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by r_level alone, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= in_flit;
        end
    end

    assign out_flit    = r_mem[r_rd_ptr];
    assign out_valid   = (r_level != '0);
    assign fifo_level  = r_level;
    assign pass_flit   = r_pass_flit;
    assign pass_enable = r_pass_enable;
    assign drop_count  = r_drop_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_flit_eject.sv
// Self-checking bench for flit_eject: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_flit_eject;

    localparam int FW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] local_id;
    logic [FW-1:0] in_flit;
    logic          in_enable;
    logic [FW-1:0] pass_flit;
    logic          pass_enable;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic          out_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CW-1:0] drop_count;
    logic          overflow;

    flit_eject #(
        .FLIT_WIDTH(FW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .CNT_WIDTH(CW), .BROADCAST_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .local_id(local_id),
        .in_flit(in_flit), .in_enable(in_enable),
        .pass_flit(pass_flit), .pass_enable(pass_enable),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [FW-1:0] m_q[$];
    logic [FW-1:0] m_pass_flit;
    bit            m_pass_en;
    int            m_drop;
    bit            m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the rules for one rising edge using the inputs held across it.
    task automatic model_edge();
        logic [AW-1:0] dest;
        bit pop, eject, fwd;
        if (!rst) begin
            m_q.delete();
            m_pass_flit = '0;
            m_pass_en   = 0;
            m_drop      = 0;
            m_ovf       = 0;
            return;
        end
        dest  = in_flit[FW-1 -: AW];
        eject = 0;
        fwd   = 0;
        if (in_enable) begin
            if (dest == local_id) eject = 1;
            else if (dest == {AW{1'b1}}) begin eject = 1; fwd = 1; end
            else fwd = 1;
        end
        pop = (m_q.size() > 0) && out_ready;
        m_pass_en = fwd;
        if (fwd) m_pass_flit = in_flit;
        if (eject) begin
            if (m_q.size() < DEPTH || pop) begin
                if (pop) void'(m_q.pop_front());
                m_q.push_back(in_flit);
                pop = 0;
            end else begin
                m_ovf = 1;
                if (m_drop < CMAX) m_drop++;
            end
        end
        if (pop) void'(m_q.pop_front());
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("out_flit", 64'(out_flit), 64'(m_q[0]));
        check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
        check("pass_enable", 64'(pass_enable), 64'(m_pass_en));
        check("pass_flit", 64'(pass_flit), 64'(m_pass_flit));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit en, input logic [FW-1:0] f, input bit rdy);
        in_enable = en;
        in_flit   = f;
        out_ready = rdy;
    endtask

    initial begin
        rst       = 1'b0;
        local_id  = 4'd3;
        drive(1, 32'h3000_0001, 0);

        // Reset held two cycles with traffic present
        tick();
        tick();
        check("rst_pass_en", 64'(pass_enable), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;

        // Forward
        drive(1, 32'h5000_00AA, 0);
        tick();
        check("fwd_flit", 64'(pass_flit), 64'h5000_00AA);
        check("fwd_en", 64'(pass_enable), 64'd1);
        drive(0, 32'h3000_0099, 0);
        tick();
        check("fwd_en_drop", 64'(pass_enable), 64'd0);
        check("fwd_level", 64'(fifo_level), 64'd0);

        // Eject order
        for (int i = 1; i <= 4; i++) begin
            drive(1, 32'h3000_0000 + 32'(i), 0);
            tick();
        end
        check("ej_level", 64'(fifo_level), 64'd4);
        check("ej_no_pass", 64'(pass_enable), 64'd0);
        drive(0, '0, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ej_head", 64'(out_flit), 64'h3000_0000 + 64'(i));
            tick();
        end
        check("ej_empty", 64'(out_valid), 64'd0);

        // Overflow and saturation
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h3000_0010 + 32'(i), 0);
            tick();
        end
        drive(1, 32'h3000_0005, 0);
        tick();
        check("ovf_cnt1", 64'(drop_count), 64'd1);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd4);
        for (int i = 0; i < 300; i++) tick();
        check("ovf_sat", 64'(drop_count), 64'd255);
        drive(1, 32'h3000_0077, 1);
        tick();
        check("full_pop_level", 64'(fifo_level), 64'd4);
        check("full_pop_cnt", 64'(drop_count), 64'd255);

        // Drain, then broadcast into an empty FIFO
        drive(0, '0, 1);
        for (int i = 0; i < 5; i++) tick();
        drive(1, 32'hF000_0042, 0);
        tick();
        check("bc_pass", 64'(pass_flit), 64'hF000_0042);
        check("bc_pass_en", 64'(pass_enable), 64'd1);
        check("bc_out", 64'(out_flit), 64'hF000_0042);
        check("bc_valid", 64'(out_valid), 64'd1);

        // Broadcast into a full FIFO: forwarded, local copy dropped
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h3000_0020 + 32'(i), 0);
            tick();
        end
        drive(1, 32'hF000_0043, 0);
        tick();
        check("bcfull_pass_en", 64'(pass_enable), 64'd1);

        // Reset mid-operation with level 3 and a forward in flight
        drive(0, '0, 1);
        tick();
        drive(1, 32'h5000_0001, 0);
        tick();
        check("mid_level3", 64'(fifo_level), 64'd3);
        rst = 1'b0;
        drive(1, 32'h3000_0033, 1);
        tick();
        check("mid_level", 64'(fifo_level), 64'd0);
        check("mid_pass_en", 64'(pass_enable), 64'd0);
        check("mid_ovf", 64'(overflow), 64'd0);
        rst = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            logic [AW-1:0] dest;
            if ($urandom_range(0, 199) == 0) local_id = AW'($urandom_range(0, 14));
            rst = ($urandom_range(0, 99) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 4) dest = local_id;
            else if (sel < 6) dest = '1;
            else dest = AW'($urandom);
            drive($urandom_range(0, 3) != 0, {dest, 28'($urandom)},
                  $urandom_range(0, 2) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_eject.md
Name: flit_eject

Overview:
- Receive-side endpoint of the node link protocol (flit + enable, no backpressure); sits on the down side of a node port.
- Ejects flits whose destination field matches this node into a local FIFO, presented to a consumer with valid/ready.
- Forwards non-matching flits unchanged with one-cycle latency so the ring continues past this endpoint.
- Counts flits lost to FIFO overflow.

Parameters:
FLIT_WIDTH, 32, total flit width in bits
ADDR_WIDTH, 4, destination field width; field = in_flit[FLIT_WIDTH-1 -: ADDR_WIDTH]
DEPTH, 4, eject FIFO depth; power of two, >= 2
CNT_WIDTH, 8, drop counter width
BROADCAST_EN, 1, when 1, dest all-ones is both ejected and forwarded

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-low (0 = reset)
local_id  input  ADDR_WIDTH  this node's address; quasi-static
in_flit  input  FLIT_WIDTH  incoming flit from link
in_enable  input  1  in_flit valid this cycle
pass_flit  output  FLIT_WIDTH  forwarded flit to next link
pass_enable  output  1  pass_flit valid
out_flit  output  FLIT_WIDTH  FIFO head to local consumer
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head
fifo_level  output  $clog2(DEPTH)+1  current occupancy
drop_count  output  CNT_WIDTH  saturating count of dropped flits
overflow  output  1  sticky: set on first drop

Behaviour:
- All state updates on rising clk. rst==0 at an edge: FIFO emptied (pointers, level = 0), pass_enable=0, pass_flit=0, drop_count=0, overflow=0. out_valid=0 and out_flit is don't-care while empty. Reset mid-operation discards all buffered and in-flight flits; nothing is forwarded or counted on that edge.
- Classification each cycle with in_enable=1, dest = in_flit[FLIT_WIDTH-1 -: ADDR_WIDTH]:
  - dest==local_id -> eject.
  - BROADCAST_EN && dest all-ones -> eject and forward.
  - otherwise -> forward.
  - in_enable=0 -> no action; in_flit ignored.
- Forward path: pass_flit/pass_enable registered. A forwarded flit at edge N appears on pass_* after edge N for exactly one cycle. pass_enable=0 on the next cycle unless another forward occurs. pass_flit holds its last value when pass_enable=0.
- Eject path:
  - push allowed if level<DEPTH, or level==DEPTH with a pop on the same edge (full + simultaneous pop accepts).
  - Pushed flit becomes visible on out_flit/out_valid after the edge (1-cycle latency); no combinational bypass.
  - When empty, push and out_ready=1 on the same edge do not pop (out_valid was 0).
- Pop: out_valid && out_ready at an edge removes the head; out_flit advances to the next entry after the edge. out_ready while !out_valid has no effect.
- Level update per edge: push-only +1, pop-only -1, both 0.
- Drop: eject requested but push not allowed. The flit is discarded (not forwarded), drop_count increments and saturates at 2^CNT_WIDTH-1, overflow set to 1 and held until reset.
- FIFO ordering strict FIFO; pointers wrap modulo DEPTH. Full/empty are distinguished by level, never by pointer equality alone.
- Broadcast with FIFO full: forwarded copy still sent; local copy dropped and counted.
- out_flit/out_valid driven from registers/RAM read of head pointer only; no input-to-output combinational path except none (out_ready affects state only).

Test Plan:
- Reset: hold rst=0 2 cycles with in_enable=1 -> pass_enable=0, out_valid=0, fifo_level=0, drop_count=0, overflow=0.
- Forward: local_id=3, in_flit=0x5000_00AA with in_enable=1 for 1 cycle -> next cycle pass_flit=0x5000_00AA, pass_enable=1; following cycle pass_enable=0; fifo_level stays 0.
- Eject order: local_id=3, out_ready=0, inject 0x3000_0001..0x3000_0004 back-to-back -> fifo_level=4, no pass_enable. Then out_ready=1 -> out_flit 0x..01,02,03,04 on consecutive cycles, then out_valid=0.
- Overflow: FIFO full, out_ready=0, inject 0x3000_0005 -> drop_count=1, overflow=1, fifo_level=4. Repeat 300 drops (CNT_WIDTH=8) -> drop_count=255. Then inject full + out_ready=1 same edge -> accepted, level stays 4, drop_count unchanged.
- Broadcast: BROADCAST_EN=1, in_flit=0xF000_0042 -> pass_enable next cycle with 0xF000_0042 and out_flit=0xF000_0042 with out_valid=1.
- Reset mid-operation: level=3, pass_enable=1, assert rst=0 one edge -> level=0, out_valid=0, pass_enable=0, overflow=0.
